fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: rd_clk cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have port rd_clk  input  1  single clock, shared with the FIFO read side; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising rd_clk.
REQ-004 The block SHALL have port enable  input  1  permits starting a new frame; sampled only in IDLE.
REQ-005 The block SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 The block SHALL have port fifo_data  input  8  upstream FIFO registered read data, valid the cycle after a read strobe.
REQ-007 The block SHALL have port fifo_rd  output  1  one-cycle read strobe to the upstream FIFO.
REQ-008 The block SHALL have port tx  output  1  serial line, idle high, 8N1 framing.
REQ-009 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL have port tx_done  output  1  one-cycle pulse on the final cycle of each stop bit.

Function
REQ-011 The state machine SHALL have states IDLE, REQ, WAIT, START, DATA and STOP; all outputs SHALL be registered or decoded from state only (Moore).
REQ-012 From IDLE, a rising edge sampling enable=1 and fifo_empty=0 SHALL move to REQ; otherwise the block SHALL stay in IDLE.
REQ-013 fifo_rd SHALL be 1 for exactly the single cycle spent in REQ and 0 in all other states; REQ SHALL always move to WAIT.
REQ-014 The edge leaving WAIT SHALL load fifo_data into an 8-bit shift register and move to START; fifo_empty SHALL be ignored in REQ and WAIT.
REQ-015 In START, tx SHALL be 0 for CLKS_PER_BIT cycles, then the block SHALL move to DATA.
REQ-016 In DATA, tx SHALL present bits 0..7, LSB first, each for CLKS_PER_BIT cycles; a 3-bit index SHALL advance at each bit boundary, and after bit 7 the block SHALL move to STOP.
REQ-017 In STOP, tx SHALL be 1 for CLKS_PER_BIT cycles; tx_done SHALL be 1 on the last of those cycles; the block SHALL then return to IDLE.
REQ-018 tx SHALL be 1 in IDLE, REQ and WAIT.
REQ-019 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and clear on every state change; it SHALL never wrap mid-bit.
REQ-020 Frame timing from the sampling edge in IDLE SHALL be: 1 REQ cycle + 1 WAIT cycle + 10*CLKS_PER_BIT line cycles.
REQ-021 Back-to-back frames SHALL keep at least one IDLE cycle between them, so the gap from the end of a stop bit to the next start bit is exactly 3 cycles while data remains.
REQ-022 Deasserting enable during a frame SHALL NOT abort it; the frame SHALL complete and the block SHALL then hold in IDLE.
REQ-023 fifo_rd SHALL never assert while fifo_empty was 1 at the sampling edge, and SHALL assert at most once per frame.

Reset
REQ-024 When reset=1 at a rising edge, the next state SHALL be IDLE with tx=1, fifo_rd=0, busy=0, tx_done=0, counters=0 and the shift register=0x00.
REQ-025 Reset during any state, including mid-bit, SHALL abort the frame immediately; a byte already strobed out of the FIFO SHALL be discarded and not retransmitted.
REQ-026 Reset SHALL take priority over enable and fifo_empty on the same edge.

Verification
REQ-027 With CLKS_PER_BIT=4, FIFO holding 0xA5 and enable=1, the bench SHALL check: fifo_rd high for exactly 1 cycle; then tx = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; tx_done pulses once; total busy time 42 cycles.
REQ-028 With fifo_empty=1 and enable=1 for 100 cycles, the bench SHALL check that fifo_rd stays 0, tx stays 1 and busy stays 0.
REQ-029 With 0x00 and 0xFF queued, the bench SHALL check: two frames, exactly 2 fifo_rd pulses, and exactly 3 tx-high cycles between the end of the first stop bit and the second start bit.
REQ-030 With 0x3C queued and enable dropped during DATA bit 2, the bench SHALL check that the frame completes unaltered, busy falls after the stop bit, and no further fifo_rd occurs.
REQ-031 With reset asserted during DATA bit 5 and fifo_empty=1, the bench SHALL check that tx=1 and busy=0 on the next cycle, tx_done stays 0, and no fifo_rd occurs.
REQ-032 With CLKS_PER_BIT=2, the bench SHALL check a minimum-rate frame of 0x81 is 20 line cycles with correct bit order.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter that pulls bytes from an upstream FIFO with a
// one-cycle registered read latency. The state machine is Moore: outputs decode from registers.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       rd_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable && !fifo_empty) w_state_next = S_REQ;
            S_REQ:   w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_START;
            S_START: if (w_bit_end) w_state_next = S_DATA;
            S_DATA:  if (w_bit_end && (r_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_bit_end) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_next;
            // The counter restarts at every state change and at each bit boundary inside DATA.
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
            end
            if (r_state == S_WAIT) begin
                r_shift <= fifo_data;
                r_idx   <= 3'd0;
            end else if (r_state == S_DATA && w_bit_end) begin
                r_shift <= {1'b0, r_shift[7:1]};
                r_idx   <= r_idx + 3'd1;
            end
        end
    end

    always_comb begin
        fifo_rd = (r_state == S_REQ);
        busy    = (r_state != S_IDLE);
        tx_done = (r_state == S_STOP) && w_bit_end;
        case (r_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = r_shift[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (4 and 2 clocks per bit) fed by FIFO models,
// with the line waveform predicted from frame arithmetic.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset4 = 1'b1, en4 = 1'b0, empty4;
    logic [7:0] data4 = 8'h00;
    logic       rd4, tx4, busy4, done4;
    logic       reset2 = 1'b1, en2 = 1'b0, empty2;
    logic [7:0] data2 = 8'h00;
    logic       rd2, tx2, busy2, done2;

    fifo_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .rd_clk(clk), .reset(reset4), .enable(en4), .fifo_empty(empty4),
        .fifo_data(data4), .fifo_rd(rd4), .tx(tx4), .busy(busy4), .tx_done(done4)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
        .rd_clk(clk), .reset(reset2), .enable(en2), .fifo_empty(empty2),
        .fifo_data(data2), .fifo_rd(rd2), .tx(tx2), .busy(busy2), .tx_done(done2)
    );

    // Upstream FIFO models: registered read data, one entry popped per strobe.
    logic [7:0] mem4 [0:63];
    logic [7:0] mem2 [0:63];
    int wp4 = 0, rp4 = 0, wp2 = 0, rp2 = 0;
    assign empty4 = (wp4 == rp4);
    assign empty2 = (wp2 == rp2);

    always @(posedge clk) begin
        if (rd4 && (rp4 != wp4)) begin
            data4 <= mem4[rp4[5:0]];
            rp4   <= rp4 + 1;
        end
        if (rd2 && (rp2 != wp2)) begin
            data2 <= mem2[rp2[5:0]];
            rp2   <= rp2 + 1;
        end
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_bytes [0:7];
    logic [3:0] cap4 [0:299];
    logic [3:0] cap2 [0:299];

    task automatic push4(input logic [7:0] b);
        mem4[wp4[5:0]] = b;
        wp4 = wp4 + 1;
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wp2[5:0]] = b;
        wp2 = wp2 + 1;
    endtask

    // Expected {fifo_rd, busy, tx, tx_done} at sample t, where sample 0 follows the
    // edge that first sees enable with data present and every frame is 3 + 10*cpb long.
    function automatic logic [3:0] model(input int t, input int cpb, input int nf);
        int   period;
        int   f;
        int   o;
        int   b;
        logic line;
        period = 3 + 10 * cpb;
        f = t / period;
        o = t % period;
        if (f >= nf || o == period - 1) return 4'b0010;
        if (o == 0) return 4'b1110;
        if (o == 1) return 4'b0110;
        b = (o - 2) / cpb;
        if (b == 0)      line = 1'b0;
        else if (b == 9) line = 1'b1;
        else             line = exp_bytes[f][b-1];
        return {1'b0, 1'b1, line, (o == period - 2)};
    endfunction

    task automatic capture(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cap4[i] = {rd4, busy4, tx4, done4};
            cap2[i] = {rd2, busy2, tx2, done2};
            if (i == drop_at) en4 = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rd4, busy4, tx4, done4} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_held4 got rd/busy/tx/done=%b expected 0010", {rd4, busy4, tx4, done4});
        end
        n_checks++;
        if ({rd2, busy2, tx2, done2} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_held2 got rd/busy/tx/done=%b expected 0010", {rd2, busy2, tx2, done2});
        end
        reset4 = 1'b0;
        reset2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rd4, busy4, tx4, done4, rd2, busy2, tx2, done2} !== 8'b0010_0010) begin
            n_fail++;
            $display("FAIL reset_release got %b expected 00100010",
                     {rd4, busy4, tx4, done4, rd2, busy2, tx2, done2});
        end
        $display("test_reset: both instances idle after reset");
    endtask

    task automatic test_single_a5();
        int rd_n, done_n, busy_n;
        logic [3:0] e;
        rd_n = 0; done_n = 0; busy_n = 0;
        exp_bytes[0] = 8'hA5;
        push4(8'hA5);
        en4 = 1'b1;
        capture(50, -1);
        for (int i = 0; i < 50; i++) begin
            e = model(i, 4, 1);
            n_checks++;
            if (cap4[i] !== e) begin
                n_fail++;
                $display("FAIL a5_cycle[%0d] got rd/busy/tx/done=%b expected %b", i, cap4[i], e);
            end
            rd_n   += int'(cap4[i][3]);
            busy_n += int'(cap4[i][2]);
            done_n += int'(cap4[i][0]);
        end
        n_checks++;
        if (rd_n !== 1) begin
            n_fail++;
            $display("FAIL a5_rd_pulses got %0d expected 1", rd_n);
        end
        n_checks++;
        if (done_n !== 1) begin
            n_fail++;
            $display("FAIL a5_done_pulses got %0d expected 1", done_n);
        end
        n_checks++;
        if (busy_n !== 42) begin
            n_fail++;
            $display("FAIL a5_busy_cycles got %0d expected 42", busy_n);
        end
        en4 = 1'b0;
        $display("test_single_a5: byte 0xa5, busy %0d cycles, %0d read strobes", busy_n, rd_n);
    endtask

    task automatic test_empty();
        en4 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({rd4, busy4, tx4} !== 3'b001) begin
                n_fail++;
                $display("FAIL empty_cycle[%0d] got rd/busy/tx=%b expected 001", i, {rd4, busy4, tx4});
            end
        end
        en4 = 1'b0;
        $display("test_empty: 100 cycles enabled with empty FIFO");
    endtask

    task automatic test_back_to_back();
        int rd_n, d, gap;
        logic [3:0] e;
        rd_n = 0; d = -1; gap = 0;
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = 8'hFF;
        push4(8'h00);
        push4(8'hFF);
        en4 = 1'b1;
        capture(95, -1);
        for (int i = 0; i < 95; i++) begin
            e = model(i, 4, 2);
            n_checks++;
            if (cap4[i] !== e) begin
                n_fail++;
                $display("FAIL b2b_cycle[%0d] got rd/busy/tx/done=%b expected %b", i, cap4[i], e);
            end
            rd_n += int'(cap4[i][3]);
            if (d < 0 && cap4[i][0]) d = i;
        end
        if (d >= 0) begin
            for (int i = d + 1; i < 95 && cap4[i][1]; i++) gap++;
        end
        n_checks++;
        if (rd_n !== 2) begin
            n_fail++;
            $display("FAIL b2b_rd_pulses got %0d expected 2", rd_n);
        end
        n_checks++;
        if (gap !== 3) begin
            n_fail++;
            $display("FAIL b2b_gap got %0d high cycles expected 3", gap);
        end
        en4 = 1'b0;
        $display("test_back_to_back: bytes 0x00,0xff, gap %0d cycles", gap);
    endtask

    task automatic test_enable_drop();
        int rd_n;
        logic [3:0] e;
        rd_n = 0;
        exp_bytes[0] = 8'h3C;
        push4(8'h3C);
        push4(8'h55);
        en4 = 1'b1;
        // Sample 15 lies inside data bit 2 (samples 14..17).
        capture(70, 15);
        for (int i = 0; i < 70; i++) begin
            e = model(i, 4, 1);
            n_checks++;
            if (cap4[i] !== e) begin
                n_fail++;
                $display("FAIL drop_cycle[%0d] got rd/busy/tx/done=%b expected %b", i, cap4[i], e);
            end
            rd_n += int'(cap4[i][3]);
        end
        n_checks++;
        if (rd_n !== 1) begin
            n_fail++;
            $display("FAIL drop_rd_pulses got %0d expected 1", rd_n);
        end
        wp4 = rp4;
        $display("test_enable_drop: byte 0x3c completed, %0d read strobes", rd_n);
    endtask

    task automatic test_reset_mid();
        logic [3:0] s, e;
        exp_bytes[0] = 8'($urandom_range(0, 255));
        push4(exp_bytes[0]);
        en4 = 1'b1;
        // Sample 27 lies inside data bit 5 (samples 26..29).
        for (int i = 0; i <= 27; i++) begin
            @(posedge clk);
            @(negedge clk);
            s = {rd4, busy4, tx4, done4};
            e = model(i, 4, 1);
            n_checks++;
            if (s !== e) begin
                n_fail++;
                $display("FAIL rstmid_cycle[%0d] got rd/busy/tx/done=%b expected %b", i, s, e);
            end
        end
        reset4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset4 = 1'b0;
        n_checks++;
        if ({rd4, busy4, tx4, done4} !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_after got rd/busy/tx/done=%b expected 0010", {rd4, busy4, tx4, done4});
        end
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({rd4, busy4, tx4, done4} !== 4'b0010) begin
                n_fail++;
                $display("FAIL rstmid_hold[%0d] got rd/busy/tx/done=%b expected 0010", i, {rd4, busy4, tx4, done4});
            end
        end
        en4 = 1'b0;
        $display("test_reset_mid: byte 0x%02h aborted in bit 5", exp_bytes[0]);
    endtask

    task automatic test_random_frames();
        int nf, n;
        logic [3:0] e;
        nf = int'($urandom_range(1, 4));
        for (int f = 0; f < nf; f++) begin
            exp_bytes[f] = 8'($urandom_range(0, 255));
            push4(exp_bytes[f]);
        end
        n = nf * 43 + 6;
        en4 = 1'b1;
        capture(n, -1);
        for (int i = 0; i < n; i++) begin
            e = model(i, 4, nf);
            n_checks++;
            if (cap4[i] !== e) begin
                n_fail++;
                $display("FAIL rand_cycle[%0d] got rd/busy/tx/done=%b expected %b", i, cap4[i], e);
            end
        end
        en4 = 1'b0;
        $display("test_random_frames: %0d frames, first byte 0x%02h", nf, exp_bytes[0]);
    endtask

    task automatic test_min_rate();
        int busy_n;
        logic [3:0] e;
        busy_n = 0;
        exp_bytes[0] = 8'h81;
        push2(8'h81);
        en2 = 1'b1;
        capture(30, -1);
        for (int i = 0; i < 30; i++) begin
            e = model(i, 2, 1);
            n_checks++;
            if (cap2[i] !== e) begin
                n_fail++;
                $display("FAIL min_cycle[%0d] got rd/busy/tx/done=%b expected %b", i, cap2[i], e);
            end
            busy_n += int'(cap2[i][2]);
        end
        n_checks++;
        if (busy_n - 2 !== 20) begin
            n_fail++;
            $display("FAIL min_line_cycles got %0d expected 20", busy_n - 2);
        end
        en2 = 1'b0;
        $display("test_min_rate: byte 0x81 at 2 clocks per bit, %0d line cycles", busy_n - 2);
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_empty();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random_frames();
        test_min_rate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
